// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the 5-stage core hazard/sequencing controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        PCTRL_RUN     = 2'd0,
        PCTRL_MC_WAIT = 2'd1,
        PCTRL_ERROR   = 2'd2
    } pctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EXE and the source operands in ID.
module pipeline_ctrl_hazard_detect #(
    parameter int GPR_ADDR_SPACE = 5
) (
    input  logic [GPR_ADDR_SPACE-1:0] i_id_rs1_addr,
    input  logic                      i_id_rs1_re,
    input  logic [GPR_ADDR_SPACE-1:0] i_id_rs2_addr,
    input  logic                      i_id_rs2_re,
    input  logic [GPR_ADDR_SPACE-1:0] i_exe_rd_addr,
    input  logic                      i_exe_rd_we,
    input  logic                      i_exe_mem_re,
    output logic                      o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_rd_valid;

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency
    assign w_rd_valid = i_exe_mem_re & i_exe_rd_we & (i_exe_rd_addr != '0);
    assign w_rs1_hit  = i_id_rs1_re & (i_id_rs1_addr == i_exe_rd_addr);
    assign w_rs2_hit  = i_id_rs2_re & (i_id_rs2_addr == i_exe_rd_addr);
    assign o_load_use = w_rd_valid & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencing for the 5-stage core: load-use, branch, multi-cycle EXE and memory waits.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int GPR_ADDR_SPACE = 5,
    parameter int MC_TIMEOUT     = 64,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [GPR_ADDR_SPACE-1:0] id_rs1_addr_i,
    input  logic                      id_rs1_re_i,
    input  logic [GPR_ADDR_SPACE-1:0] id_rs2_addr_i,
    input  logic                      id_rs2_re_i,
    input  logic [GPR_ADDR_SPACE-1:0] exe_rd_addr_i,
    input  logic                      exe_rd_we_i,
    input  logic                      exe_mem_re_i,
    input  logic                      exe_branch_taken_i,
    input  logic                      exe_mc_start_i,
    input  logic                      exe_mc_done_i,
    input  logic                      mem_ready_i,
    output logic                      pc_stall_o,
    output logic                      if_id_stall_o,
    output logic                      if_id_flush_o,
    output logic                      id_exe_stall_o,
    output logic                      id_exe_flush_o,
    output logic                      exe_mem_stall_o,
    output logic                      exe_mem_flush_o,
    output logic                      mem_wb_flush_o,
    output logic                      err_o,
    output logic [CNT_WIDTH-1:0]      stall_cnt_o,
    output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

    localparam int                    MC_CNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [MC_CNT_W-1:0]   MC_LAST  = MC_CNT_W'(MC_TIMEOUT - 1);

    pctrl_state_e          r_state;
    pctrl_state_e          w_state_nxt;
    logic [MC_CNT_W-1:0]   r_mc_cnt;
    logic [MC_CNT_W-1:0]   w_mc_cnt_nxt;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;
    logic [CNT_WIDTH-1:0]  r_flush_cnt;
    logic                  w_load_use;
    logic                  w_hold;
    logic                  w_lu_act;
    logic                  w_br_act;
    logic                  w_pc_stall;
    logic                  w_if_id_stall;
    logic                  w_id_exe_stall;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    pipeline_ctrl_hazard_detect #(
        .GPR_ADDR_SPACE(GPR_ADDR_SPACE)
    ) u_hazard_detect (
        .i_id_rs1_addr (id_rs1_addr_i),
        .i_id_rs1_re   (id_rs1_re_i),
        .i_id_rs2_addr (id_rs2_addr_i),
        .i_id_rs2_re   (id_rs2_re_i),
        .i_exe_rd_addr (exe_rd_addr_i),
        .i_exe_rd_we   (exe_rd_we_i),
        .i_exe_mem_re  (exe_mem_re_i),
        .o_load_use    (w_load_use)
    );

    // Priority chain: ERROR > memory wait > MC_WAIT > branch > multi-cycle start > load-use
    always_comb begin
        w_state_nxt  = r_state;
        w_mc_cnt_nxt = r_mc_cnt;
        w_hold       = 1'b0;
        w_lu_act     = 1'b0;
        w_br_act     = 1'b0;
        if (r_state == PCTRL_ERROR) begin
            w_hold = 1'b1;
        end else if (!mem_ready_i) begin
            w_hold = 1'b1;
        end else if (r_state == PCTRL_MC_WAIT) begin
            if (exe_mc_done_i) begin
                w_state_nxt = PCTRL_RUN;
            end else begin
                w_hold = 1'b1;
                if (r_mc_cnt == MC_LAST) begin
                    w_state_nxt = PCTRL_ERROR;
                end else begin
                    w_mc_cnt_nxt = r_mc_cnt + MC_CNT_W'(1);
                end
            end
        end else if (exe_branch_taken_i) begin
            w_br_act = 1'b1;
        end else if (exe_mc_start_i) begin
            w_hold       = 1'b1;
            w_state_nxt  = PCTRL_MC_WAIT;
            w_mc_cnt_nxt = '0;
        end else begin
            w_lu_act = w_load_use;
        end
    end

    assign w_pc_stall     = w_hold | w_lu_act;
    assign w_if_id_stall  = w_hold | w_lu_act;
    assign w_id_exe_stall = w_hold;

    // A register's own stall always masks its flush; reset forces every control low
    assign pc_stall_o      = rst_i & w_pc_stall;
    assign if_id_stall_o   = rst_i & w_if_id_stall;
    assign if_id_flush_o   = rst_i & w_br_act & ~w_if_id_stall;
    assign id_exe_stall_o  = rst_i & w_id_exe_stall;
    assign id_exe_flush_o  = rst_i & (w_br_act | w_lu_act) & ~w_id_exe_stall;
    assign exe_mem_stall_o = rst_i & w_hold;
    assign exe_mem_flush_o = 1'b0;
    assign mem_wb_flush_o  = rst_i & w_hold;
    assign err_o           = (r_state == PCTRL_ERROR);
    assign stall_cnt_o     = r_stall_cnt;
    assign flush_cnt_o     = r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= PCTRL_RUN;
            r_mc_cnt    <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_cnt <= w_mc_cnt_nxt;
            if (w_pc_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
            if (w_br_act)   r_flush_cnt <= sat_inc(r_flush_cnt);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench: short-timeout/4-bit-counter instance plus a default-parameter instance.
module tb_pipeline_ctrl;

    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b1100_1000;
    localparam logic [7:0] C_BR   = 8'b0010_1000;
    localparam logic [7:0] C_HOLD = 8'b1101_0101;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] rs1, rs2, rd;
    logic       rs1_re, rs2_re, rd_we, mem_re, br, mc_start, mc_done, mem_ready;

    logic       pc_s, ifid_s, ifid_f, idex_s, idex_f, exm_s, exm_f, mwb_f, err;
    logic [3:0] stall_cnt, flush_cnt;
    logic       pc_s_w, ifid_s_w, ifid_f_w, idex_s_w, idex_f_w, exm_s_w, exm_f_w, mwb_f_w, err_w;
    logic [31:0] stall_cnt_w, flush_cnt_w;
    logic [7:0] ctl, ctl_w;

    int n_chk = 0;
    int n_pass = 0;

    assign ctl   = {pc_s, ifid_s, ifid_f, idex_s, idex_f, exm_s, exm_f, mwb_f};
    assign ctl_w = {pc_s_w, ifid_s_w, ifid_f_w, idex_s_w, idex_f_w, exm_s_w, exm_f_w, mwb_f_w};

    always #5 clk = ~clk;

    pipeline_ctrl #(.GPR_ADDR_SPACE(5), .MC_TIMEOUT(8), .CNT_WIDTH(4)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .id_rs1_addr_i(rs1), .id_rs1_re_i(rs1_re), .id_rs2_addr_i(rs2), .id_rs2_re_i(rs2_re),
        .exe_rd_addr_i(rd), .exe_rd_we_i(rd_we), .exe_mem_re_i(mem_re),
        .exe_branch_taken_i(br), .exe_mc_start_i(mc_start), .exe_mc_done_i(mc_done),
        .mem_ready_i(mem_ready),
        .pc_stall_o(pc_s), .if_id_stall_o(ifid_s), .if_id_flush_o(ifid_f),
        .id_exe_stall_o(idex_s), .id_exe_flush_o(idex_f),
        .exe_mem_stall_o(exm_s), .exe_mem_flush_o(exm_f), .mem_wb_flush_o(mwb_f),
        .err_o(err), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    pipeline_ctrl u_dut_w (
        .clk_i(clk), .rst_i(rst_i),
        .id_rs1_addr_i(rs1), .id_rs1_re_i(rs1_re), .id_rs2_addr_i(rs2), .id_rs2_re_i(rs2_re),
        .exe_rd_addr_i(rd), .exe_rd_we_i(rd_we), .exe_mem_re_i(mem_re),
        .exe_branch_taken_i(br), .exe_mc_start_i(mc_start), .exe_mc_done_i(mc_done),
        .mem_ready_i(mem_ready),
        .pc_stall_o(pc_s_w), .if_id_stall_o(ifid_s_w), .if_id_flush_o(ifid_f_w),
        .id_exe_stall_o(idex_s_w), .id_exe_flush_o(idex_f_w),
        .exe_mem_stall_o(exm_s_w), .exe_mem_flush_o(exm_f_w), .mem_wb_flush_o(mwb_f_w),
        .err_o(err_w), .stall_cnt_o(stall_cnt_w), .flush_cnt_o(flush_cnt_w)
    );

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        rs1_re = 1'b0; rs2_re = 1'b0; rd_we = 1'b0; mem_re = 1'b0;
        br = 1'b0; mc_start = 1'b0; mc_done = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b0;
        br = 1'b1; mem_ready = 1'b0; mc_start = 1'b1;
        #1;
        n_chk++; if (ctl !== C_NONE) $display("FAIL reset_ctl: got %b want %b", ctl, C_NONE); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        n_chk++; if ({stall_cnt, flush_cnt} !== 8'h00) $display("FAIL reset_cnt: got %h want 00", {stall_cnt, flush_cnt}); else n_pass++;
        do_reset();
        n_chk++; if (ctl !== C_NONE) $display("FAIL reset_idle_ctl: got %b want %b", ctl, C_NONE); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        mem_re = 1'b1; rd_we = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_re = 1'b1;
        #1;
        n_chk++; if (ctl !== C_LU) $display("FAIL lu_rs1: got %b want %b", ctl, C_LU); else n_pass++;
        tick();
        mem_re = 1'b0; rd_we = 1'b0;
        #1;
        n_chk++; if (ctl !== C_NONE) $display("FAIL lu_bubble: got %b want %b", ctl, C_NONE); else n_pass++;
        n_chk++; if (stall_cnt !== 4'd1) $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); else n_pass++;
        mem_re = 1'b1; rd_we = 1'b1; rd = 5'd0; rs1 = 5'd0;
        #1;
        n_chk++; if (ctl !== C_NONE) $display("FAIL lu_rd0: got %b want %b", ctl, C_NONE); else n_pass++;
        rd = 5'd7; rs1 = 5'd7; rs1_re = 1'b0;
        #1;
        n_chk++; if (ctl !== C_NONE) $display("FAIL lu_re0: got %b want %b", ctl, C_NONE); else n_pass++;
        rs2 = 5'd7; rs2_re = 1'b1;
        #1;
        n_chk++; if (ctl !== C_LU) $display("FAIL lu_rs2: got %b want %b", ctl, C_LU); else n_pass++;
        tick();
        idle();
        #1;
        n_chk++; if (stall_cnt !== 4'd2) $display("FAIL lu_stall_cnt2: got %0d want 2", stall_cnt); else n_pass++;
    endtask

    task automatic test_branch();
        do_reset();
        br = 1'b1;
        #1;
        n_chk++; if (ctl !== C_BR) $display("FAIL br_flush: got %b want %b", ctl, C_BR); else n_pass++;
        tick();
        br = 1'b0;
        #1;
        n_chk++; if (ctl !== C_NONE) $display("FAIL br_one_cycle: got %b want %b", ctl, C_NONE); else n_pass++;
        n_chk++; if (flush_cnt !== 4'd1) $display("FAIL br_flush_cnt: got %0d want 1", flush_cnt); else n_pass++;
        br = 1'b1; mem_re = 1'b1; rd_we = 1'b1; rd = 5'd3; rs1 = 5'd3; rs1_re = 1'b1;
        #1;
        n_chk++; if (ctl !== C_BR) $display("FAIL br_over_lu: got %b want %b", ctl, C_BR); else n_pass++;
        tick();
        idle();
        #1;
        n_chk++; if ({stall_cnt, flush_cnt} !== {4'd0, 4'd2}) $display("FAIL br_cnts: got %h want 02", {stall_cnt, flush_cnt}); else n_pass++;
        br = 1'b1; mc_start = 1'b1;
        #1;
        n_chk++; if (ctl !== C_BR) $display("FAIL br_over_start: got %b want %b", ctl, C_BR); else n_pass++;
        tick();
        idle();
        #1;
        n_chk++; if (ctl !== C_NONE) $display("FAIL br_start_ignored: got %b want %b", ctl, C_NONE); else n_pass++;
    endtask

    task automatic test_multicycle();
        do_reset();
        mc_start = 1'b1;
        #1;
        n_chk++; if (ctl_w !== C_HOLD) $display("FAIL mc_start_cycle: got %b want %b", ctl_w, C_HOLD); else n_pass++;
        tick();
        mc_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_chk++; if (ctl_w !== C_HOLD) $display("FAIL mc_wait_%0d: got %b want %b", i, ctl_w, C_HOLD); else n_pass++;
            tick();
        end
        mc_done = 1'b1;
        #1;
        n_chk++; if (ctl_w !== C_NONE) $display("FAIL mc_done_cycle: got %b want %b", ctl_w, C_NONE); else n_pass++;
        tick();
        mc_done = 1'b0;
        #1;
        n_chk++; if (ctl_w !== C_NONE) $display("FAIL mc_back_run: got %b want %b", ctl_w, C_NONE); else n_pass++;
        n_chk++; if (err_w !== 1'b0) $display("FAIL mc_err: got %b want 0", err_w); else n_pass++;
        n_chk++; if (stall_cnt_w !== 32'd11) $display("FAIL mc_stall_cnt: got %0d want 11", stall_cnt_w); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        mc_start = 1'b1;
        tick();
        mc_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_chk++; if ({ctl, err} !== {C_HOLD, 1'b0}) $display("FAIL to_wait_%0d: got %b want %b", i, {ctl, err}, {C_HOLD, 1'b0}); else n_pass++;
            tick();
        end
        n_chk++; if (err !== 1'b1) $display("FAIL to_err_set: got %b want 1", err); else n_pass++;
        mc_done = 1'b1;
        #1;
        n_chk++; if (ctl !== C_HOLD) $display("FAIL to_err_hold: got %b want %b", ctl, C_HOLD); else n_pass++;
        tick();
        n_chk++; if (err !== 1'b1) $display("FAIL to_err_sticky: got %b want 1", err); else n_pass++;
        n_chk++; if (stall_cnt !== 4'd10) $display("FAIL to_stall_cnt: got %0d want 10", stall_cnt); else n_pass++;
        repeat (10) tick();
        n_chk++; if (stall_cnt !== 4'd15) $display("FAIL sat_stall_cnt: got %0d want 15", stall_cnt); else n_pass++;
        rst_i = 1'b0;
        #1;
        n_chk++; if ({ctl, err, stall_cnt} !== 13'd0) $display("FAIL to_reset_clear: got %b want 0", {ctl, err, stall_cnt}); else n_pass++;
        rst_i = 1'b1;
        idle();
        #1;
    endtask

    task automatic test_mem_wait();
        do_reset();
        mc_start = 1'b1;
        tick();
        mc_start = 1'b0;
        repeat (2) tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (ctl !== C_HOLD) $display("FAIL mw_hold_%0d: got %b want %b", i, ctl, C_HOLD); else n_pass++;
            tick();
        end
        mem_ready = 1'b1;
        repeat (5) tick();
        n_chk++; if (err !== 1'b0) $display("FAIL mw_frozen: got %b want 0", err); else n_pass++;
        tick();
        n_chk++; if (err !== 1'b1) $display("FAIL mw_delayed_to: got %b want 1", err); else n_pass++;
        do_reset();
        mem_ready = 1'b0; br = 1'b1;
        #1;
        n_chk++; if (ctl !== C_HOLD) $display("FAIL mw_br_suppr: got %b want %b", ctl, C_HOLD); else n_pass++;
        tick();
        n_chk++; if (flush_cnt !== 4'd0) $display("FAIL mw_br_cnt: got %0d want 0", flush_cnt); else n_pass++;
        mem_ready = 1'b1;
        #1;
        n_chk++; if (ctl !== C_BR) $display("FAIL mw_br_retry: got %b want %b", ctl, C_BR); else n_pass++;
        tick();
        idle();
        n_chk++; if (flush_cnt !== 4'd1) $display("FAIL mw_br_cnt2: got %0d want 1", flush_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_mc();
        do_reset();
        mc_start = 1'b1;
        tick();
        mc_start = 1'b0;
        repeat (2) tick();
        #2;
        rst_i = 1'b0;
        #1;
        n_chk++; if ({ctl_w, err_w} !== 9'd0) $display("FAIL rst_mid_ctl: got %b want 0", {ctl_w, err_w}); else n_pass++;
        n_chk++; if ({stall_cnt_w, flush_cnt_w} !== 64'd0) $display("FAIL rst_mid_cnt: got %h want 0", {stall_cnt_w, flush_cnt_w}); else n_pass++;
        #1;
        rst_i = 1'b1;
        #1;
        n_chk++; if (ctl_w !== C_NONE) $display("FAIL rst_mid_run: got %b want %b", ctl_w, C_NONE); else n_pass++;
        tick();
        n_chk++; if (ctl_w !== C_NONE) $display("FAIL rst_mid_run2: got %b want %b", ctl_w, C_NONE); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_multicycle();
        test_timeout();
        test_mem_wait();
        test_reset_mid_mc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage core (IF, ID, EXE, MEM, WB).
- Drives the stall and flush controls of PC, IF_ID, ID_EXE, EXE_MEM and MEM_WB.
- Handles load-use bubbles, taken-branch flushes, multi-cycle EXE operations (with a watchdog) and data-memory wait states.
- Replaces the constant flush/sel ties in Core and keeps saturating stall and flush counters for performance debug.

Parameters:
- GPR_ADDR_SPACE, 5, register address width.
- MC_TIMEOUT, 64, maximum cycles in MC_WAIT before the error state.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- id_rs1_addr_i  in  GPR_ADDR_SPACE  rs1 of the instruction in ID.
- id_rs1_re_i  in  1  rs1 read enable.
- id_rs2_addr_i  in  GPR_ADDR_SPACE  rs2 of the instruction in ID.
- id_rs2_re_i  in  1  rs2 read enable.
- exe_rd_addr_i  in  GPR_ADDR_SPACE  rd of the instruction in EXE.
- exe_rd_we_i  in  1  EXE rd write enable.
- exe_mem_re_i  in  1  instruction in EXE is a load.
- exe_branch_taken_i  in  1  taken branch/jump resolved in EXE.
- exe_mc_start_i  in  1  pulse: multi-cycle EXE op begins.
- exe_mc_done_i  in  1  multi-cycle result valid this cycle.
- mem_ready_i  in  1  data memory completes this cycle.
- pc_stall_o  out  1  hold PC.
- if_id_stall_o  out  1  hold IF_ID.
- if_id_flush_o  out  1  IF_ID loads a NOP.
- id_exe_stall_o  out  1  hold ID_EXE.
- id_exe_flush_o  out  1  ID_EXE loads a bubble.
- exe_mem_stall_o  out  1  hold EXE_MEM.
- exe_mem_flush_o  out  1  EXE_MEM loads a bubble.
- mem_wb_flush_o  out  1  MEM_WB loads a bubble.
- err_o  out  1  sticky multi-cycle timeout.
- stall_cnt_o  out  CNT_WIDTH  cycles with pc_stall_o=1.
- flush_cnt_o  out  CNT_WIDTH  taken-branch flush events.

Behaviour:
- Reset:
  - While rst_i=0, state=RUN, mc counter=0, err_o=0, both perf counters=0.
  - All stall/flush outputs are forced to 0 during reset.
  - Reset asserted mid-MC_WAIT aborts the wait immediately; no pending state survives.
- States: RUN, MC_WAIT, ERROR. Registered state; stall/flush outputs are combinational from state and inputs, zero latency.
- Load-use:
  - Condition: exe_mem_re_i & exe_rd_we_i & exe_rd_addr_i!=0 & ((id_rs1_re_i & rs1==rd) | (id_rs2_re_i & rs2==rd)).
  - Response: pc_stall, if_id_stall and id_exe_flush for exactly that cycle.
  - The bubble clears the condition on the next cycle, giving exactly one cycle per hazard.
- Branch: exe_branch_taken_i=1 asserts if_id_flush and id_exe_flush for that cycle, with no stall. flush_cnt increments.
- Multi-cycle:
  - exe_mc_start_i in RUN moves RUN to MC_WAIT at the next edge.
  - In the start cycle itself, assert pc/if_id/id_exe/exe_mem stalls (mc op held in EXE) plus mem_wb_flush.
  - Those same outputs are held every MC_WAIT cycle while exe_mc_done_i=0.
  - On the cycle exe_mc_done_i=1, all stalls deassert and the state moves to RUN at the next edge.
  - The mc counter increments each MC_WAIT cycle and clears on entry.
  - If the counter reaches MC_TIMEOUT-1 with no done, the state moves to ERROR.
  - exe_mc_start_i is ignored outside RUN.
- ERROR: all stalls plus mem_wb_flush asserted permanently, err_o=1. Exit only by reset.
- Memory wait:
  - mem_ready_i=0 stalls PC, IF_ID, ID_EXE and EXE_MEM, and asserts mem_wb_flush.
  - State is unchanged and the mc counter is frozen.
  - Branch and load-use actions are suppressed that cycle and re-evaluated the next cycle.
- Priority (high to low): ERROR > memory wait > MC_WAIT > branch flush > load-use. Branch together with mc_start: branch wins and the start is ignored.
- A stall and a flush on the same register are never both 1. Flush is suppressed by that register's stall.
- Counters: +1 per qualifying cycle, saturating at all-ones with no wrap.
- rd/rs address 0 never produces a hazard.

Decomposition:
- conf_general_define.v gains the state encodings PCTRL_RUN=2'd0, PCTRL_MC_WAIT=2'd1, PCTRL_ERROR=2'd2.
- conf_riscv_spec.v already supplies GPR_ADDR_SPACE.
- One combinational sub-module, hazard_detect, implements the load-use compare.
- FSM, mc counter, priority mux and perf counters stay in pipeline_ctrl.

Test Plan:
- Load-use: rd=5 load in EXE, ID rs1=5 re=1 -> exactly one cycle of pc_stall=if_id_stall=id_exe_flush=1; rd=0 or re=0 gives 0 stalls; stall_cnt=1.
- Branch: exe_branch_taken_i pulse of 1 cycle -> if_id_flush=id_exe_flush=1 for that cycle only, no stalls; flush_cnt=1. Branch together with load-use -> flush only, no stall.
- Multi-cycle: start, then done after 10 cycles -> 11 stall cycles (start cycle plus 10 MC_WAIT) with exe_mem_stall=1 and mem_wb_flush=1; stalls drop on the done cycle; RUN afterwards; err_o=0.
- Timeout: MC_TIMEOUT=8, start with no done -> ERROR after 8 MC_WAIT cycles, err_o=1 sticky, stalls held; rst_i=0 clears everything.
- Memory wait: mem_ready_i=0 for 3 cycles during MC_WAIT with done held 0 -> mc counter frozen (timeout delayed by 3); mem_ready_i=0 alongside a taken branch -> no flush that cycle.
- Saturation and reset: preload a counter near max via long stalls (CNT_WIDTH=4) -> stall_cnt sticks at 15; asserting rst_i asynchronously mid-MC_WAIT zeroes outputs immediately.
